mnist_image_loader: RTL and testbench

//  UART-to-image-RAM writer feeding the MNIST classifier. Receives 8N1 serial bytes, hunts for a

---
 rtl/mnist_image_loader.sv | 194 +++++++++++++++++++
 tb/tb_mnist_image_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_image_loader.sv
// mnist_image_loader
// UART (8N1) receiver plus frame FSM that hunts for a sync byte and then
// writes NUM_PIXELS pixel bytes into the classifier's 784x8 image RAM.
// image_valid flags a complete frame until the consumer returns image_ack.
module mnist_image_loader #(
    parameter int         CLK_HZ         = 50_000_000,
    parameter int         BAUD           = 115_200,
    parameter int         NUM_PIXELS     = 784,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 5_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       uart_rxd,
    output logic       img_wr_en,
    output logic [9:0] img_wr_addr,
    output logic [7:0] img_wr_data,
    output logic       image_valid,
    input  logic       image_ack,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int GAP_W        = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);
    localparam logic [9:0]       LAST_ADDR = 10'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {F_HUNT, F_LOAD, F_READY} frame_state_t;

    // Synchronizer and edge-detect history
    logic r_rxd_meta;
    logic r_rxd_sync;
    logic r_rxd_prev;

    // Receiver state
    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic             r_byte_err;

    // Frame state
    frame_state_t     r_frame_state;
    logic [9:0]       r_addr;
    logic [GAP_W-1:0] r_gap_cnt;

    // Bring the asynchronous serial line into the clock domain; the extra stage
    // gives the previous value for falling-edge detection.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        // NOTE: the line idles high, so these reset to 1 to avoid a false start bit after reset.
        if (!reset_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep this a true shift chain regardless of statement order.
            r_rxd_meta <= uart_rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    // 8N1 receiver: verify the start bit at half a bit, then sample data and stop
    // bits one full bit apart so every sample lands mid-bit.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state   <= R_IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte_err   <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle and are raised only on the cycle they fire.
            r_byte_valid <= 1'b0;
            r_byte_err   <= 1'b0;
            case (r_rx_state)
                R_IDLE: begin
                    r_clk_cnt <= '0;
                    if (r_rxd_prev && !r_rxd_sync) begin
                        r_rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt <= '0;
                        if (!r_rxd_sync) begin
                            r_bit_idx  <= '0;
                            r_rx_state <= R_DATA;
                        end else begin
                            r_rx_state <= R_IDLE;   // glitch, not a real start bit
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rxd_sync, r_shift[7:1]};   // LSB arrives first
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= R_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt  <= '0;
                        r_rx_state <= R_IDLE;
                        if (r_rxd_sync) begin
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_byte_err <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end

    // Frame FSM: hunt for sync, load pixels with gap timeout, hold the frame
    // until acknowledged. All outputs are registered here.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_state <= F_HUNT;
            r_addr        <= '0;
            r_gap_cnt     <= '0;
            img_wr_en     <= 1'b0;
            img_wr_addr   <= '0;
            img_wr_data   <= '0;
            image_valid   <= 1'b0;
            frame_err     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            img_wr_en <= 1'b0;
            case (r_frame_state)
                F_HUNT: begin
                    if (r_byte_valid && (r_shift == SYNC_BYTE)) begin
                        r_frame_state <= F_LOAD;
                        r_addr        <= '0;
                        r_gap_cnt     <= '0;
                        frame_err     <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                F_LOAD: begin
                    if (r_byte_valid) begin
                        r_gap_cnt   <= '0;
                        img_wr_en   <= 1'b1;
                        img_wr_addr <= r_addr;
                        img_wr_data <= r_shift;
                        if (r_addr == LAST_ADDR) begin
                            r_frame_state <= F_READY;
                            image_valid   <= 1'b1;
                            busy          <= 1'b0;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end else if (r_byte_err || (r_gap_cnt == GAP_LIMIT)) begin
                        r_frame_state <= F_HUNT;
                        frame_err     <= 1'b1;
                        busy          <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;   // leaving at GAP_LIMIT caps it
                    end
                end
                F_READY: begin
                    // Bytes arriving here are discarded; ack takes priority over them.
                    if (image_ack) begin
                        image_valid   <= 1'b0;
                        r_frame_state <= F_HUNT;
                    end
                end
                default: r_frame_state <= F_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_mnist_image_loader.sv
// Directed bench for mnist_image_loader using a fast baud rate and a short
// frame so complete frames fit in a few thousand clocks.
module tb_mnist_image_loader;

    localparam int   CPB      = 8;          // 8 MHz / 1 MBd
    localparam int   NUM_PIX  = 16;
    localparam int   TIMEOUT  = 400;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic       uart_rxd;
    logic       img_wr_en;
    logic [9:0] img_wr_addr;
    logic [7:0] img_wr_data;
    logic       image_valid;
    logic       image_ack;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Write log captured by the monitor
    logic [9:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         back_to_back   = 0;
    int         valid_rise_cnt = 0;
    int         valid_rise_ok  = 0;
    logic       prev_en        = 1'b0;
    logic       prev_valid     = 1'b0;

    mnist_image_loader #(
        .CLK_HZ         (8_000_000),
        .BAUD           (1_000_000),
        .NUM_PIXELS     (NUM_PIX),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .uart_rxd    (uart_rxd),
        .img_wr_en   (img_wr_en),
        .img_wr_addr (img_wr_addr),
        .img_wr_data (img_wr_data),
        .image_valid (image_valid),
        .image_ack   (image_ack),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Monitor samples 1 ns after each rising edge.
    always @(posedge CLOCK_50) begin
        #1;
        if (img_wr_en) begin
            wr_addr_q.push_back(img_wr_addr);
            wr_data_q.push_back(img_wr_data);
            if (prev_en) back_to_back++;
        end
        if (image_valid && !prev_valid) begin
            valid_rise_cnt++;
            if (img_wr_en && (img_wr_addr == 10'(NUM_PIX - 1))) valid_rise_ok++;
        end
        prev_en    = img_wr_en;
        prev_valid = image_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int i, input int mul, input int seed);
        int v;
        v = (i * mul + seed) & 255;
        return 8'(v);
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            wait_clk(CPB);
        end
        uart_rxd = stop_bit;
        wait_clk(CPB);
        uart_rxd = 1'b1;
        wait_clk(4);
    endtask

    task automatic send_frame(input int mul, input int seed);
        send_byte(SYNC, 1'b1);
        for (int i = 0; i < NUM_PIX; i++) send_byte(pix(i, mul, seed), 1'b1);
        wait_clk(6);
    endtask

    task automatic check_frame(input string tag, input int mul, input int seed);
        check({tag, "_count"}, wr_addr_q.size(), NUM_PIX);
        for (int i = 0; i < wr_addr_q.size() && i < NUM_PIX; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i);
            check($sformatf("%s_data%0d", tag, i), wr_data_q[i], pix(i, mul, seed));
        end
    endtask

    task automatic ack_pulse();
        image_ack = 1'b1;
        wait_clk(1);
        image_ack = 1'b0;
        wait_clk(2);
    endtask

    initial begin
        uart_rxd  = 1'b1;
        image_ack = 1'b0;
        reset_n   = 1'b0;
        wait_clk(5);
        check("rst_wr_en", img_wr_en, 0);
        check("rst_addr", img_wr_addr, 0);
        check("rst_data", img_wr_data, 0);
        check("rst_valid", image_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        wait_clk(5);

        // Full frame, data equals address
        clear_log();
        send_byte(SYNC, 1'b1);
        wait_clk(4);
        check("t1_busy_sync", busy, 1);
        for (int i = 0; i < NUM_PIX; i++) send_byte(pix(i, 1, 0), 1'b1);
        wait_clk(6);
        check_frame("t1", 1, 0);
        check("t1_valid", image_valid, 1);
        check("t1_busy_done", busy, 0);
        check("t1_rise_cnt", valid_rise_cnt, 1);
        check("t1_rise_with_last", valid_rise_ok, 1);

        // Extra bytes while READY are ignored; ack returns to hunt
        clear_log();
        send_byte(SYNC, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_clk(6);
        check("t5_no_writes", wr_addr_q.size(), 0);
        check("t5_valid_held", image_valid, 1);
        ack_pulse();
        check("t5_valid_clr", image_valid, 0);
        send_byte(8'h11, 1'b1);
        wait_clk(6);
        check("t5_hunt_no_write", wr_addr_q.size(), 0);
        check("t5_hunt_busy", busy, 0);
        send_byte(8'h22, 1'b0);
        wait_clk(6);
        check("hunt_byte_err_ignored", frame_err, 0);

        // Junk before sync, frame with SYNC value as data at pixel 1
        clear_log();
        send_byte(8'h00, 1'b1);
        send_byte(8'h3C, 1'b1);
        wait_clk(6);
        check("t2_junk_no_write", wr_addr_q.size(), 0);
        check("t2_junk_busy", busy, 0);
        send_frame(37, 8'h80);
        check_frame("t2", 37, 8'h80);
        check("t2_valid", image_valid, 1);
        ack_pulse();

        // Framing error mid-frame
        clear_log();
        send_byte(SYNC, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(pix(i, 3, 7), 1'b1);
        send_byte(8'h55, 1'b0);
        wait_clk(6);
        check("t3_err", frame_err, 1);
        check("t3_busy", busy, 0);
        check("t3_valid", image_valid, 0);
        check("t3_partial", wr_addr_q.size(), 5);
        clear_log();
        send_byte(SYNC, 1'b1);
        wait_clk(2);
        check("t3_err_cleared", frame_err, 0);
        check("t3_busy_again", busy, 1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h78, 1'b1);
        check("t3_restart_count", wr_addr_q.size(), 2);
        if (wr_addr_q.size() > 0) check("t3_restart_addr", wr_addr_q[0], 0);

        // Gap timeout: still loading just below the limit, aborted past it
        wait_clk(300);
        check("t4_not_early_busy", busy, 1);
        check("t4_not_early_err", frame_err, 0);
        wait_clk(150);
        check("t4_timeout_err", frame_err, 1);
        check("t4_timeout_busy", busy, 0);
        check("t4_timeout_valid", image_valid, 0);
        clear_log();
        send_frame(5, 8'h21);
        check_frame("t4", 5, 8'h21);
        check("t4_reload_valid", image_valid, 1);
        check("t4_reload_err", frame_err, 0);
        ack_pulse();

        // Reset mid-frame
        clear_log();
        send_byte(SYNC, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(pix(i, 1, 0), 1'b1);
        check("t6_pre_busy", busy, 1);
        check("t6_pre_addr", img_wr_addr, 7);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_wr_en", img_wr_en, 0);
        check("t6_rst_addr", img_wr_addr, 0);
        check("t6_rst_data", img_wr_data, 0);
        check("t6_rst_valid", image_valid, 0);
        check("t6_rst_err", frame_err, 0);
        check("t6_rst_busy", busy, 0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        wait_clk(4);
        clear_log();
        for (int i = 8; i < 12; i++) send_byte(pix(i, 1, 0), 1'b1);
        wait_clk(6);
        check("t6_no_write", wr_addr_q.size(), 0);
        check("t6_busy", busy, 0);
        check("t6_valid", image_valid, 0);

        check("no_back_to_back", back_to_back, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
